// File: rtl/key_sequence_lock.sv
// Keypad sequence lock: collects SEQ_LEN key symbols and checks them
// against PASSCODE, driving unlock, error pulse and lockout status.
// Ports: clk, rst_n (async, active-low); key_code[1:0], key_valid from
// the key encoder; unlocked, error, locked_out, entry_count, fail_count.
module key_sequence_lock #(
  parameter int SEQ_LEN        = 4,
  parameter logic [2*SEQ_LEN-1:0] PASSCODE = (2*SEQ_LEN)'(8'h1B),
  parameter int MAX_FAIL       = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int EW = $clog2(SEQ_LEN+1),
  localparam int FW = $clog2(MAX_FAIL+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    key_code,
  input  logic          key_valid,
  output logic          unlocked,
  output logic          error,
  output logic          locked_out,
  output logic [EW-1:0] entry_count,
  output logic [FW-1:0] fail_count
);

  localparam int SW = 2*(SEQ_LEN-1);
  localparam int HM = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                      UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int CW = $clog2(HM+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  localparam logic [EW-1:0] ELAST = EW'(SEQ_LEN-1);
  localparam logic [FW-1:0] FMAX  = FW'(MAX_FAIL);
  localparam logic [CW-1:0] UMAX  = CW'(UNLOCK_CYCLES-1);
  localparam logic [CW-1:0] LMAX  = CW'(LOCKOUT_CYCLES-1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES-1);

  typedef enum logic [1:0] {
    IDLE, ENTRY, OPEN, LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic          valid_q;
  logic [SW-1:0] shreg_q, shreg_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          unl_q, unl_d;
  logic          err_q, err_d;
  logic          lock_q, lock_d;

  logic                 press;
  logic [2*SEQ_LEN-1:0] cand;
  logic [FW-1:0]        fail_inc;

  assign press = key_valid & ~valid_q;
  // Candidate sequence: stored symbols plus the symbol pressed now.
  assign cand  = {shreg_q, key_code};
  assign fail_inc = (fail_q == FMAX) ? fail_q : fail_q + FW'(1);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    entry_d = entry_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    unl_d   = 1'b0;
    err_d   = 1'b0;
    lock_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          shreg_d = cand[SW-1:0];
          entry_d = EW'(1);
          timer_d = '0;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (press) begin
          if (entry_q < ELAST) begin
            shreg_d = cand[SW-1:0];
            entry_d = entry_q + EW'(1);
            timer_d = '0;
          end else begin
            shreg_d = '0;
            entry_d = '0;
            cnt_d   = '0;
            if (cand == PASSCODE) begin
              unl_d   = 1'b1;
              fail_d  = '0;
              state_d = OPEN;
            end else begin
              err_d  = 1'b1;
              fail_d = fail_inc;
              if (fail_inc == FMAX) begin
                lock_d  = 1'b1;
                state_d = LOCKOUT;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end else if (timer_q >= TMAX) begin
          // Timeout aborts the attempt but is not counted as a failure.
          err_d   = 1'b1;
          entry_d = '0;
          shreg_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      OPEN: begin
        if (cnt_q >= UMAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          unl_d = 1'b1;
        end
      end
      LOCKOUT: begin
        if (cnt_q >= LMAX) begin
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          lock_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      shreg_q <= '0;
      entry_q <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      unl_q   <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= key_valid;
      shreg_q <= shreg_d;
      entry_q <= entry_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      unl_q   <= unl_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
    end
  end

  assign unlocked    = unl_q;
  assign error       = err_q;
  assign locked_out  = lock_q;
  assign entry_count = entry_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_key_sequence_lock.sv
// Directed bench for key_sequence_lock with an expected-status queue.
// Status word: {unlocked, error, locked_out, entry_count[2:0], fail_count[1:0]}.
module tb_key_sequence_lock;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_code = 2'd0;
  logic       key_valid = 1'b0;
  logic       unlocked;
  logic       error;
  logic       locked_out;
  logic [2:0] entry_count;
  logic [1:0] fail_count;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];

  key_sequence_lock dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .unlocked   (unlocked),
    .error      (error),
    .locked_out (locked_out),
    .entry_count(entry_count),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] st();
    return {unlocked, error, locked_out, entry_count, fail_count};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(string tag, bit u, bit e, bit l,
                           int en, int f);
    exp_t x;
    x.tag = tag;
    x.exp = {u, e, l, 3'(en), 2'(f)};
    sbq.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'(sbq.size()), 32'd1);
    end else begin
      x = sbq.pop_front();
      chk(x.tag, 32'(st()), 32'(x.exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c);
    key_code = c;
    key_valid = 1'b1;
    tick();
    tick();
    key_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Raises valid and returns just after the edge that samples the press.
  task automatic final_press(input logic [1:0] c);
    key_code = c;
    key_valid = 1'b1;
    tick();
  endtask

  task automatic release_key();
    tick();
    key_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lk;
    int odd;
    int idle;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    expect_st("reset", 0, 0, 0, 0, 0);
    pop_check();
    rst_n = 1'b1;
    tick();

    // Correct sequence 0,1,2,3
    press(2'd0);
    press(2'd1);
    press(2'd2);
    expect_st("ok_cnt3", 0, 0, 0, 3, 0);
    pop_check();
    final_press(2'd3);
    expect_st("ok_open", 1, 0, 0, 0, 0);
    pop_check();
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) key_valid = 1'b0;
      tick();
      if (unlocked) n++;
    end
    chk("unlock_len", 32'(n), 32'd8);
    expect_st("after_open", 0, 0, 0, 0, 0);
    pop_check();

    // Held key counts once
    key_code = 2'd0;
    key_valid = 1'b1;
    repeat (10) tick();
    key_valid = 1'b0;
    tick();
    expect_st("held_once", 0, 0, 0, 1, 0);
    pop_check();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Wrong sequence 0,1,2,2
    press(2'd0);
    press(2'd1);
    press(2'd2);
    final_press(2'd2);
    expect_st("wrong1", 0, 1, 0, 0, 1);
    pop_check();
    tick();
    expect_st("err_pulse1", 0, 0, 0, 0, 1);
    pop_check();
    key_valid = 1'b0;
    n = 0;
    repeat (5) begin
      tick();
      if (unlocked) n++;
    end
    chk("wrong_no_unl", 32'(n), 32'd0);

    // Second and third wrong attempts -> lockout
    press(2'd0);
    press(2'd0);
    press(2'd0);
    final_press(2'd0);
    expect_st("wrong2", 0, 1, 0, 0, 2);
    pop_check();
    release_key();
    press(2'd3);
    press(2'd3);
    press(2'd3);
    final_press(2'd3);
    expect_st("wrong3_lock", 0, 1, 1, 0, 3);
    pop_check();
    lk = 1;
    odd = 0;
    for (int i = 0; i < 30; i++) begin
      key_valid = (i < 8) && (i % 2 == 1);
      key_code = 2'(i / 2);
      tick();
      if (locked_out) lk++;
      if (unlocked || entry_count != 3'd0) odd++;
    end
    chk("lock_len", 32'(lk), 32'd16);
    chk("lock_ignored", 32'(odd), 32'd0);
    expect_st("after_lock", 0, 0, 0, 0, 0);
    pop_check();
    press(2'd0);
    press(2'd1);
    press(2'd2);
    final_press(2'd3);
    expect_st("relock_open", 1, 0, 0, 0, 0);
    pop_check();
    key_valid = 1'b0;
    repeat (12) tick();

    // Timeout: fail_count must survive
    press(2'd0);
    press(2'd0);
    press(2'd0);
    final_press(2'd0);
    expect_st("pre_to_fail", 0, 1, 0, 0, 1);
    pop_check();
    release_key();
    press(2'd0);
    key_code = 2'd1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    expect_st("timeout", 0, 1, 0, 0, 1);
    idle = 0;
    while (!error && idle < 100) begin
      tick();
      idle++;
    end
    chk("timeout_idle", 32'(idle), 32'd64);
    pop_check();
    tick();
    chk("timeout_pulse", 32'(error), 32'd0);

    // Reset mid-entry
    press(2'd0);
    press(2'd1);
    press(2'd2);
    expect_st("pre_rst", 0, 0, 0, 3, 1);
    pop_check();
    rst_n = 1'b0;
    #2;
    expect_st("async_rst", 0, 0, 0, 0, 0);
    pop_check();
    tick();
    rst_n = 1'b1;
    tick();
    final_press(2'd3);
    expect_st("rst_press", 0, 0, 0, 1, 0);
    pop_check();
    key_valid = 1'b0;
    repeat (10) tick();
    expect_st("rst_no_unl", 0, 0, 0, 1, 0);
    pop_check();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
